// File: rtl/chain_add_scheduler.sv
// chain_add_scheduler: two-requester, round-robin chained adder.
// A granted requester streams signed operands that are summed into an
// accumulator; the chain closes on a 'last' beat or after MAX_TERMS beats,
// and the result is held on the output until the consumer takes it.
// A sticky flag records whether any partial sum left the interval [LO,HI].
// Optional feature: define CHAIN_ADD_CLAMP_EN to saturate each out-of-interval
// partial sum to LO/HI; otherwise partial sums wrap to WIDTH bits.
module chain_add_scheduler #(
  parameter int WIDTH     = 16,
  parameter int MAX_TERMS = 8,
  parameter int LO        = -1000,
  parameter int HI        = 1000
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_in_0_valid,
  output logic             io_in_0_ready,
  input  logic [WIDTH-1:0] io_in_0_bits_data,
  input  logic             io_in_0_bits_last,
  input  logic             io_in_1_valid,
  output logic             io_in_1_ready,
  input  logic [WIDTH-1:0] io_in_1_bits_data,
  input  logic             io_in_1_bits_last,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [WIDTH-1:0] io_out_bits_sum,
  output logic             io_out_bits_src,
  output logic             io_out_bits_ovf,
  output logic             io_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  // Interval bounds widened by one bit so they compare directly with the
  // unwrapped partial sum.
  localparam logic signed [WIDTH:0] LO_EXT  = (WIDTH+1)'(LO);
  localparam logic signed [WIDTH:0] HI_EXT  = (WIDTH+1)'(HI);
  localparam logic [7:0]            MAX_CNT = 8'(MAX_TERMS);

  state_t           state, state_next;
  logic             grant, grant_next;
  logic             last_src, last_src_next;
  logic [WIDTH-1:0] acc, acc_next;
  logic [7:0]       cnt, cnt_next;
  logic             ovf, ovf_next;

  logic             valid_g;
  logic             last_g;
  logic [WIDTH-1:0] data_g;
  logic signed [WIDTH:0] sum_ext;
  logic             below_lo;
  logic             above_hi;
  logic [WIDTH-1:0] acc_step;
  logic [7:0]       cnt_inc;
  logic             chain_end;
  logic             pick;

  // Granted-requester datapath: exact partial sum, range test, stored value.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    valid_g  = grant ? io_in_1_valid     : io_in_0_valid;
    last_g   = grant ? io_in_1_bits_last : io_in_0_bits_last;
    data_g   = grant ? io_in_1_bits_data : io_in_0_bits_data;
    sum_ext  = {acc[WIDTH-1], acc} + {data_g[WIDTH-1], data_g};
    below_lo = sum_ext < LO_EXT;
    above_hi = sum_ext > HI_EXT;
    acc_step = sum_ext[WIDTH-1:0];
`ifdef CHAIN_ADD_CLAMP_EN
    if (below_lo) acc_step = LO_EXT[WIDTH-1:0];
    if (above_hi) acc_step = HI_EXT[WIDTH-1:0];
`endif
    cnt_inc   = cnt + 8'd1;
    chain_end = last_g || (cnt_inc == MAX_CNT);
    // Round-robin: on contention favour the requester not served last.
    if (io_in_0_valid && io_in_1_valid) pick = ~last_src;
    else                                pick = io_in_1_valid;
  end

  // Next-state and output decode for the IDLE -> ACC -> OUT sequence.
  always_comb begin
    state_next      = state;
    grant_next      = grant;
    last_src_next   = last_src;
    acc_next        = acc;
    cnt_next        = cnt;
    ovf_next        = ovf;
    io_in_0_ready   = 1'b0;
    io_in_1_ready   = 1'b0;
    io_out_valid    = 1'b0;
    io_out_bits_sum = '0;
    io_out_bits_src = 1'b0;
    io_out_bits_ovf = 1'b0;
    io_busy         = 1'b0;
    case (state)
      S_IDLE: begin
        if (io_in_0_valid || io_in_1_valid) begin
          grant_next = pick;
          acc_next   = '0;
          cnt_next   = '0;
          ovf_next   = 1'b0;
          state_next = S_ACC;
        end
      end
      S_ACC: begin
        io_busy       = 1'b1;
        io_in_0_ready = ~grant;
        io_in_1_ready = grant;
        // A missing beat simply stalls; nothing changes until it arrives.
        if (valid_g) begin
          acc_next = acc_step;
          cnt_next = cnt_inc;
          if (below_lo || above_hi) ovf_next = 1'b1;
          if (chain_end) state_next = S_OUT;
        end
      end
      S_OUT: begin
        io_busy         = 1'b1;
        io_out_valid    = 1'b1;
        io_out_bits_sum = acc;
        io_out_bits_src = grant;
        io_out_bits_ovf = ovf;
        if (io_out_ready) begin
          last_src_next = grant;
          state_next    = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // State register; reset drops any chain in flight and restores priority to 0.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state    <= S_IDLE;
      grant    <= 1'b0;
      last_src <= 1'b1;
      acc      <= '0;
      cnt      <= '0;
      ovf      <= 1'b0;
    end else begin
      state    <= state_next;
      grant    <= grant_next;
      last_src <= last_src_next;
      acc      <= acc_next;
      cnt      <= cnt_next;
      ovf      <= ovf_next;
    end
  end

endmodule

// File: doc/chain_add_scheduler.md
CHAIN_ADD_SCHEDULER -- requirements
Module: chain_add_scheduler

Interface
REQ-001 SHALL have parameter WIDTH, default 16, signed operand/sum width.
REQ-002 SHALL have parameter MAX_TERMS, default 8, maximum beats per chain (2..255).
REQ-003 SHALL have parameter LO, default -1000, lower interval bound (signed, WIDTH bits).
REQ-004 SHALL have parameter HI, default 1000, upper interval bound (signed, HI >= LO).
REQ-005 SHALL have port clock  input  1  sole clock, all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-007 SHALL have ports io_in_N_valid  input  1  requester N (N=0,1) offers an operand.
REQ-008 SHALL have ports io_in_N_ready  output  1  operand of requester N accepted this cycle.
REQ-009 SHALL have ports io_in_N_bits_data  input  WIDTH  signed operand of requester N.
REQ-010 SHALL have ports io_in_N_bits_last  input  1  final operand of requester N's chain.
REQ-011 SHALL have port io_out_valid  output  1  result held.
REQ-012 SHALL have port io_out_ready  input  1  consumer accepts result.
REQ-013 SHALL have port io_out_bits_sum  output  WIDTH  signed chained sum.
REQ-014 SHALL have port io_out_bits_src  output  1  requester index that produced the sum.
REQ-015 SHALL have port io_out_bits_ovf  output  1  sticky: some partial sum left [LO,HI].
REQ-016 SHALL have port io_busy  output  1  high in every state except IDLE.

Function
REQ-017 SHALL implement FSM IDLE -> ACC -> OUT -> IDLE.
REQ-018 IDLE: ready outputs 0; when any io_in_N_valid, SHALL latch grant, clear acc, term count, ovf; go ACC next cycle.
REQ-019 Arbitration SHALL be round-robin: both valid -> grant requester not served last; after reset requester 0 has priority.
REQ-020 ACC: only granted io_in_g_ready = 1; each valid beat SHALL add data to acc in WIDTH+1-bit signed arithmetic, increment term count.
REQ-021 Partial sum outside [LO,HI] SHALL set ovf, which remains set until next IDLE grant.
REQ-022 Beat with last=1, or beat making term count equal MAX_TERMS, SHALL end chain; FSM enters OUT next cycle.
REQ-023 Latency: io_out_valid SHALL assert exactly one cycle after final accepted beat.
REQ-024 OUT: io_out_valid=1, sum/src/ovf stable while io_out_ready=0; all io_in ready 0.
REQ-025 On io_out_valid && io_out_ready SHALL record src as last served, return to IDLE next cycle.
REQ-026 Non-granted requester valid during ACC/OUT SHALL be ignored and not lost (ready stays 0).
REQ-027 Granted valid dropping mid-chain SHALL stall ACC with no state change.

Reset
REQ-028 reset SHALL force IDLE, acc=0, term count=0, ovf=0, priority to requester 0, regardless of state.
REQ-029 While and after reset: io_out_valid=0, io_in_N_ready=0, io_busy=0, io_out_bits_sum=0, io_out_bits_src=0, io_out_bits_ovf=0.
REQ-030 reset mid-chain SHALL discard the chain; no partial result emitted.

Configuration
REQ-031 Macro CHAIN_ADD_CLAMP_EN defined: each out-of-interval partial sum SHALL saturate to LO or HI before storage; ovf still set.
REQ-032 Macro CHAIN_ADD_CLAMP_EN undefined: partial sums SHALL wrap to WIDTH bits two's complement; only ovf flags range violation.

Verification
REQ-033 Requester 0 sends 3,4,5(last), out_ready=1 -> sum=12, src=0, ovf=0, out_valid one cycle after beat 5.
REQ-034 Both valid from IDLE after reset, chains 1(last) and 2(last) -> results src 0 then src 1; third concurrent request -> src 0.
REQ-035 Requester 1 sends 900,200(last) -> ovf=1; sum=1000 with CHAIN_ADD_CLAMP_EN, 1100 without.
REQ-036 Requester 0 sends 8 beats of 1, none last -> chain ends at 8th beat, sum=8; 9th beat waits for next grant.
REQ-037 Hold out_ready=0 for 5 cycles in OUT -> sum/src/ovf stable, both in ready 0; ready=1 -> IDLE next cycle.
REQ-038 Assert reset after second beat of a chain -> all outputs zero next cycle, no out_valid, new chain sums from 0.
